signed_frame_collector: RTL and testbench
=========================================

# signed_frame_collector

Upstream stage for the signed-array consumer modules in the design. It accepts a valid/ready stream of narrow signed samples and sign-extends each to `WIDTH` bits. It packs up to `DEPTH` samples into one flattened frame, e.g. the `[DEPTH]` × `[WIDTH-1:0]` signed array port of the downstream module. It holds the frame, with its element count and a running signed sum, until the consumer accepts it.

## Interface
Parameters:
- `WIDTH`, default 8: output element width; signed.
- `IN_W`, default 4: input sample width; signed; legal range 1..`WIDTH`.
- `DEPTH`, default 8: elements per frame; legal range 2..64.
- Derived `CW` = `$clog2(DEPTH+1)`.
- Derived `SW` = `WIDTH + $clog2(DEPTH)`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `in_valid`  in  1  input sample present.
- `in_ready`  out  1  collector can accept a sample.
- `in_data`  in  `IN_W`  signed input sample.
- `in_last`  in  1  this sample closes the frame early.
- `out_valid`  out  1  frame available.
- `out_ready`  in  1  consumer accepts the frame.
- `out_data`  out  `DEPTH*WIDTH`  frame; element k at `[k*WIDTH +: WIDTH]`; element 0 is the first sample received.
- `out_count`  out  `CW`  number of valid elements, 1..`DEPTH`.
- `out_sum`  out  `SW`  signed sum of the valid elements; cannot overflow.

## Operation
- Two states: `FILL` and `HOLD`. Reset state is `FILL`.
- `in_ready` = (state==`FILL`) && !`rst`.
- `out_valid` = (state==`HOLD`).
- Accept occurs when `in_valid` && `in_ready`. On accept:
  - element[`wr_ptr`] <= sign-extend(`in_data`) to `WIDTH`.
  - `sum` <= `sum` + sign-extend(`in_data`) to `SW`.
  - `wr_ptr` increments.
- `FILL`→`HOLD` on an accept where `wr_ptr`==`DEPTH-1` or `in_last`==1.
  - `out_count` <= `wr_ptr`+1.
  - `in_last` on the `DEPTH`-th sample is not an error; the frame closes once.
- `in_last` with no accept is ignored.
- In `HOLD`:
  - `out_data`, `out_count` and `out_sum` are stable.
  - Elements at index ≥ `out_count` read 0.
- `HOLD`→`FILL` on `out_valid` && `out_ready`. In the same edge:
  - `wr_ptr`, `sum` and all elements clear to 0.
- No sample is accepted in the cycle the frame is taken; `in_ready` rises the cycle after.
- A zero-length frame never occurs.
- In `FILL`, `out_data` and `out_sum` show partial contents. They are not qualified by `out_valid`.
- Reset mid-frame discards all partial or held data.

## Timing
- Reset values:
  - `in_ready`=0 while `rst` is high, 1 after release.
  - `out_valid`=0, `out_count`=0, `out_sum`=0, `out_data`=0.
  - Internal `wr_ptr`=0.
- Latency: the closing sample is accepted at edge N, and `out_valid`=1 from edge N (visible in cycle N+1).
- Throughput: `DEPTH` accept cycles + at least 1 `HOLD` cycle per frame. Maximum is `DEPTH`/(`DEPTH`+1) samples per cycle.
- All outputs are registered except `in_ready` and `out_valid`, which are pure state decodes.
- `in_data` is sampled only on accept edges. `out_ready` is sampled only in `HOLD`.
- Back-pressure is unbounded: the frame is held indefinitely with no loss.
- No combinational path exists from `out_ready` to `in_ready`.

## Test plan
- Parameters for all scenarios: `WIDTH`=8, `IN_W`=4, `DEPTH`=4.
1. Reset check: assert `rst` asynchronously mid-cycle -> immediately `in_ready`=0 and `out_valid`=0. After release, `in_ready`=1 and all outputs are 0.
2. Full frame, sign extension: inputs 4'b1000, 4'b0111, 4'b1111, 4'b0001 -> `out_data` elements 8'hF8, 8'h07, 8'hFF, 8'h01; `out_count`=4; `out_sum`=-1 (10'h3FF); `out_valid` one cycle after the 4th accept.
3. Early close: 4'b1010 then 4'b0011 with `in_last` -> `out_count`=2; elements 8'hFA, 8'h03, 0, 0; `out_sum`=-3.
4. Back-pressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 throughout -> `in_ready`=0 and the frame stays stable for 10 cycles. Then `out_ready`=1 for 1 cycle -> `in_ready`=1 next cycle, and the next frame starts at element 0 with sum 0.
5. Extremes: four samples of 4'b1000 -> `out_sum`=-32; four samples of 4'b0111 -> `out_sum`=+28; no wrap.
6. Reset mid-frame: accept 2 samples, pulse `rst`, then send 4 samples of 4'b0001 -> `out_count`=4, `out_sum`=4, no residue from the earlier samples.

Source files
------------

// File: rtl/signed_frame_collector_if.sv
// Stream-in / frame-out bundle for signed_frame_collector.
// Upstream side: in_valid, in_ready, in_data, in_last.
// Downstream side: out_valid, out_ready, out_data, out_count, out_sum.
// The slave modport is the collector; the master modport is its environment.
interface signed_frame_collector_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = WIDTH + $clog2(DEPTH);

  logic                   in_valid;
  logic                   in_ready;
  logic [IN_W-1:0]        in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DEPTH*WIDTH-1:0] out_data;
  logic [CW-1:0]          out_count;
  logic [SW-1:0]          out_sum;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_sum
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_sum
  );
endinterface

// File: rtl/signed_frame_collector.sv
// Collects narrow signed samples into a frame of up to DEPTH sign-extended
// WIDTH-bit elements, with element count and running signed sum, and holds
// the frame until the consumer takes it.
// Ports: clk, rst (async active-high), bus (slave side of
// signed_frame_collector_if: sample stream in, frame out).
module signed_frame_collector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN_W  = 4,
  parameter int unsigned DEPTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  signed_frame_collector_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = WIDTH + $clog2(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] elem_q;
  logic [CW-1:0]               wr_ptr;
  logic [CW-1:0]               count_q;
  logic [SW-1:0]               sum_q;
  logic signed [IN_W-1:0]      din_s;
  logic                        accept;
  logic                        close;
  logic                        take;

  assign din_s = bus.in_data;

  // Handshake decodes; in_ready drops immediately with rst.
  always_comb begin
    accept = bus.in_valid && (state == FILL) && !rst;
    close  = accept && ((wr_ptr == CW'(DEPTH - 1)) || bus.in_last);
    take   = (state == HOLD) && bus.out_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (close) state_nxt = HOLD;
      HOLD: if (take)  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Frame storage: clears on take so unused elements of the next frame read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_q  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      sum_q   <= '0;
    end else if (take) begin
      elem_q  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      sum_q   <= '0;
    end else if (accept) begin
      elem_q[wr_ptr[PW-1:0]] <= WIDTH'(din_s);
      sum_q                  <= sum_q + SW'(din_s);
      wr_ptr                 <= wr_ptr + CW'(1);
      if (close) count_q <= wr_ptr + CW'(1);
    end
  end

  assign bus.in_ready  = (state == FILL) && !rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = elem_q;
  assign bus.out_count = count_q;
  assign bus.out_sum   = sum_q;
endmodule

// File: tb/tb_signed_frame_collector.sv
// Directed bench for signed_frame_collector with WIDTH=8, IN_W=4, DEPTH=4.
module tb_signed_frame_collector;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IN_W  = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [3:0]  d;
    logic        last;
    logic [31:0] exp_data;
    logic [9:0]  exp_sum;
    logic        exp_valid;
    logic [2:0]  exp_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[14];

  signed_frame_collector_if #(.WIDTH(WIDTH), .IN_W(IN_W), .DEPTH(DEPTH)) bus ();

  signed_frame_collector #(.WIDTH(WIDTH), .IN_W(IN_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Take the held frame and check the collector comes back empty in FILL.
  task automatic take_frame(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_take_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_take_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_take_sum"},   64'(bus.out_sum), 64'd0);
    chk({tag, "_take_data"},  64'(bus.out_data), 64'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Full frame with sign extension
    vecs[0]  = '{4'b1000, 1'b0, 32'h000000F8, 10'h3F8, 1'b0, 3'd0};
    vecs[1]  = '{4'b0111, 1'b0, 32'h000007F8, 10'h3FF, 1'b0, 3'd0};
    vecs[2]  = '{4'b1111, 1'b0, 32'h00FF07F8, 10'h3FE, 1'b0, 3'd0};
    vecs[3]  = '{4'b0001, 1'b0, 32'h01FF07F8, 10'h3FF, 1'b1, 3'd4};
    // Early close with in_last
    vecs[4]  = '{4'b1010, 1'b0, 32'h000000FA, 10'h3FA, 1'b0, 3'd0};
    vecs[5]  = '{4'b0011, 1'b1, 32'h000003FA, 10'h3FD, 1'b1, 3'd2};
    // Most negative samples
    vecs[6]  = '{4'b1000, 1'b0, 32'h000000F8, 10'h3F8, 1'b0, 3'd0};
    vecs[7]  = '{4'b1000, 1'b0, 32'h0000F8F8, 10'h3F0, 1'b0, 3'd0};
    vecs[8]  = '{4'b1000, 1'b0, 32'h00F8F8F8, 10'h3E8, 1'b0, 3'd0};
    vecs[9]  = '{4'b1000, 1'b0, 32'hF8F8F8F8, 10'h3E0, 1'b1, 3'd4};
    // Most positive samples, in_last coinciding with the DEPTH-th sample
    vecs[10] = '{4'b0111, 1'b0, 32'h00000007, 10'h007, 1'b0, 3'd0};
    vecs[11] = '{4'b0111, 1'b0, 32'h00000707, 10'h00E, 1'b0, 3'd0};
    vecs[12] = '{4'b0111, 1'b0, 32'h00070707, 10'h015, 1'b0, 3'd0};
    vecs[13] = '{4'b0111, 1'b1, 32'h07070707, 10'h01C, 1'b1, 3'd4};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_count", 64'(bus.out_count), 64'd0);
    chk("post_rst_sum", 64'(bus.out_sum), 64'd0);
    chk("post_rst_data", 64'(bus.out_data), 64'd0);

    // Asynchronous reset asserted mid-cycle over a partial frame
    send(4'b0111, 1'b0);
    send(4'b0110, 1'b0);
    chk("partial_data", 64'(bus.out_data), 64'h0607);
    chk("partial_sum", 64'(bus.out_sum), 64'd13);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_sum", 64'(bus.out_sum), 64'd0);
    chk("async_rst_data", 64'(bus.out_data), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("async_rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Table-driven frames
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      send(vecs[i].d, vecs[i].last);
      chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_data", i), 64'(bus.out_data), 64'(vecs[i].exp_data));
      chk($sformatf("v%0d_sum", i), 64'(bus.out_sum), 64'(vecs[i].exp_sum));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_count", i), 64'(bus.out_count), 64'(vecs[i].exp_cnt));
        chk($sformatf("v%0d_hold_ready", i), 64'(bus.in_ready), 64'd0);
        take_frame($sformatf("v%0d", i));
      end
    end

    // Back-pressure: frame 2,2,2,3 held while upstream keeps offering 5
    send(4'b0010, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b0011, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
      chk($sformatf("bp%0d_valid", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp%0d_data", c), 64'(bus.out_data), 64'h03020202);
      chk($sformatf("bp%0d_sum", c), 64'(bus.out_sum), 64'd9);
      chk($sformatf("bp%0d_count", c), 64'(bus.out_count), 64'd4);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_take_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_take_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_take_data", 64'(bus.out_data), 64'd0);
    chk("bp_take_sum", 64'(bus.out_sum), 64'd0);
    tick();
    chk("bp_next_data", 64'(bus.out_data), 64'h05);
    chk("bp_next_sum", 64'(bus.out_sum), 64'd5);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next2_data", 64'(bus.out_data), 64'h0505);
    chk("bp_next2_sum", 64'(bus.out_sum), 64'd10);

    // Reset mid-frame, then a clean frame of four +1 samples
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) send(4'b0001, 1'b0);
    chk("mf_valid", 64'(bus.out_valid), 64'd1);
    chk("mf_count", 64'(bus.out_count), 64'd4);
    chk("mf_sum", 64'(bus.out_sum), 64'd4);
    chk("mf_data", 64'(bus.out_data), 64'h01010101);
    take_frame("mf");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
